// File: rtl/axis_stall_deadlock_detector.sv
// Per-region deadlock detector: flags a deadlock when one nonzero blocked-channel set persists unchanged
// while the kernel is not fully idle. Optional DEADLOCK_REPORT_EN adds a simulation-only report and sticky flag.
module axis_stall_deadlock_detector #(
    parameter int NUM_AXIS        = 3,
    parameter int NUM_INST        = 3,
    parameter int NUM_IBLK        = 1,
    parameter int STALL_THRESHOLD = 16,
    parameter int CNT_W           = 16
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic [NUM_AXIS-1:0]          axis_block_sigs,
    input  logic [NUM_INST-1:0]          inst_idle_sigs,
    input  logic [NUM_IBLK-1:0]          inst_block_sigs,
    input  logic                         clear,
    output logic                         block,
    output logic [NUM_AXIS+NUM_IBLK-1:0] block_vec,
    output logic [CNT_W-1:0]             stall_cnt,
    output logic [CNT_W-1:0]             event_cnt
);

    localparam int              VEC_W  = NUM_AXIS + NUM_IBLK;
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(STALL_THRESHOLD);
    localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WATCH   = 2'd1,
        ST_BLOCKED = 2'd2
    } state_t;

    state_t           state_r;
    logic [VEC_W-1:0] snapshot_r;
    logic [VEC_W-1:0] cur_s;
    logic             stall_s;
    logic             same_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    // A drained kernel (every sub-instance idle) never counts as stalled.
    always_comb begin
        cur_s   = {inst_block_sigs, axis_block_sigs};
        stall_s = (|cur_s) & ~(&inst_idle_sigs);
        same_s  = (cur_s == snapshot_r);
    end

    // Detector state machine with registered outputs; clear acts as a synchronous soft reset.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n || clear) begin
            state_r    <= ST_IDLE;
            snapshot_r <= {VEC_W{1'b0}};
            block      <= 1'b0;
            block_vec  <= {VEC_W{1'b0}};
            stall_cnt  <= {CNT_W{1'b0}};
            event_cnt  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (stall_s) begin
                        state_r    <= ST_WATCH;
                        snapshot_r <= cur_s;
                        stall_cnt  <= ONE;
                    end else begin
                        stall_cnt  <= {CNT_W{1'b0}};
                    end
                end
                ST_WATCH: begin
                    if (!stall_s) begin
                        state_r    <= ST_IDLE;
                        stall_cnt  <= {CNT_W{1'b0}};
                    end else if (!same_s) begin
                        snapshot_r <= cur_s;
                        stall_cnt  <= ONE;
                    end else if (sat_inc(stall_cnt) == THRESH) begin
                        state_r    <= ST_BLOCKED;
                        block      <= 1'b1;
                        block_vec  <= snapshot_r;
                        event_cnt  <= sat_inc(event_cnt);
                        stall_cnt  <= THRESH;
                    end else begin
                        stall_cnt  <= sat_inc(stall_cnt);
                    end
                end
                ST_BLOCKED: begin
                    if (!stall_s) begin
                        state_r    <= ST_IDLE;
                        block      <= 1'b0;
                        stall_cnt  <= {CNT_W{1'b0}};
                    end else if (!same_s) begin
                        state_r    <= ST_WATCH;
                        block      <= 1'b0;
                        snapshot_r <= cur_s;
                        stall_cnt  <= ONE;
                    end else begin
                        stall_cnt  <= sat_inc(stall_cnt);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    block      <= 1'b0;
                    stall_cnt  <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

`ifdef DEADLOCK_REPORT_EN
    logic block_d_r;
    logic deadlock_seen_r;

    // Reports each fresh detection once its outputs have settled; deadlock_seen_r stays set until reset.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            block_d_r       <= 1'b0;
            deadlock_seen_r <= 1'b0;
        end else begin
            block_d_r <= block;
            if (block && !block_d_r) begin
                deadlock_seen_r <= 1'b1;
                $display("[%0t] axis_stall_deadlock_detector: deadlock block_vec=%b event_cnt=%0d",
                         $time, block_vec, event_cnt);
            end else begin
                deadlock_seen_r <= deadlock_seen_r;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_stall_deadlock_detector.sv
// Randomized and directed bench for axis_stall_deadlock_detector against a run-length reference model.
module tb_axis_stall_deadlock_detector;

    localparam int THR   = 16;
    localparam int CMAX  = 65535;

    logic       ap_clk = 1'b0;
    logic       ap_rst_n;
    logic [2:0] axis_block_sigs;
    logic [2:0] inst_idle_sigs;
    logic [0:0] inst_block_sigs;
    logic       clear;
    logic       block;
    logic [3:0] block_vec;
    logic [15:0] stall_cnt;
    logic [15:0] event_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: length of the current run of identical stall sets.
    int       m_run  = 0;
    logic [3:0] m_prev = 4'd0;
    logic [3:0] m_vec  = 4'd0;
    int       m_evt  = 0;

    axis_stall_deadlock_detector #(
        .NUM_AXIS(3), .NUM_INST(3), .NUM_IBLK(1), .STALL_THRESHOLD(THR), .CNT_W(16)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
        .inst_block_sigs(inst_block_sigs), .clear(clear),
        .block(block), .block_vec(block_vec), .stall_cnt(stall_cnt), .event_cnt(event_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, compare every output.
    task automatic step(input logic [2:0] a, input logic [2:0] idle, input logic b,
                        input logic clr, input logic rst_n);
        logic [3:0] cur;
        logic       st;
        axis_block_sigs = a;
        inst_idle_sigs  = idle;
        inst_block_sigs = b;
        clear           = clr;
        ap_rst_n        = rst_n;
        @(posedge ap_clk);
        #1;
        cur = {b, a};
        st  = (cur != 4'd0) && (idle != 3'b111);
        if (!rst_n || clr) begin
            m_run  = 0;
            m_prev = 4'd0;
            m_vec  = 4'd0;
            m_evt  = 0;
        end else begin
            if (!st)                            m_run = 0;
            else if (m_run > 0 && cur == m_prev) m_run = (m_run == CMAX) ? CMAX : m_run + 1;
            else                                m_run = 1;
            if (st) m_prev = cur;
            if (m_run == THR) begin
                m_vec = cur;
                m_evt = (m_evt == CMAX) ? CMAX : m_evt + 1;
            end
        end
        check_value("block",     {31'd0, block},     {31'd0, (m_run >= THR)});
        check_value("block_vec", {28'd0, block_vec}, {28'd0, m_vec});
        check_value("stall_cnt", {16'd0, stall_cnt}, m_run);
        check_value("event_cnt", {16'd0, event_cnt}, m_evt);
    endtask

    initial begin
        axis_block_sigs = 3'd0;
        inst_idle_sigs  = 3'd0;
        inst_block_sigs = 1'b0;
        clear           = 1'b0;
        ap_rst_n        = 1'b0;

        // Reset and idle
        for (int i = 0; i < 3; i++) step(3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        check_value("reset_block", {31'd0, block}, 32'd0);
        check_value("reset_evt", {16'd0, event_cnt}, 32'd0);

        // Constant stall reaches threshold
        step(3'b001, 3'b000, 1'b0, 1'b0, 1'b1);
        check_value("t2_first_cnt", {16'd0, stall_cnt}, 32'd1);
        for (int i = 1; i < THR - 1; i++) step(3'b001, 3'b000, 1'b0, 1'b0, 1'b1);
        check_value("t2_pre_block", {31'd0, block}, 32'd0);
        step(3'b001, 3'b000, 1'b0, 1'b0, 1'b1);
        check_value("t2_block", {31'd0, block}, 32'd1);
        check_value("t2_vec", {28'd0, block_vec}, 32'h1);
        check_value("t2_evt", {16'd0, event_cnt}, 32'd1);
        for (int i = 0; i < 4; i++) step(3'b001, 3'b000, 1'b0, 1'b0, 1'b1);

        // Release for one cycle, then re-stall
        step(3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        check_value("t4_release", {31'd0, block}, 32'd0);
        check_value("t4_vec_kept", {28'd0, block_vec}, 32'h1);
        for (int i = 0; i < THR; i++) step(3'b001, 3'b000, 1'b0, 1'b0, 1'b1);
        check_value("t4_evt2", {16'd0, event_cnt}, 32'd2);
        step(3'b000, 3'b000, 1'b0, 1'b0, 1'b1);

        // Changing stall set restarts the count
        for (int i = 0; i < 10; i++) step(3'b010, 3'b000, 1'b0, 1'b0, 1'b1);
        step(3'b100, 3'b000, 1'b0, 1'b0, 1'b1);
        check_value("t3_restart", {16'd0, stall_cnt}, 32'd1);
        for (int i = 0; i < 9; i++) step(3'b100, 3'b000, 1'b0, 1'b0, 1'b1);
        check_value("t3_noblock", {31'd0, block}, 32'd0);

        // Fully idle kernel is never a stall
        for (int i = 0; i < 40; i++) step(3'b111, 3'b111, 1'b1, 1'b0, 1'b1);
        check_value("t5_block", {31'd0, block}, 32'd0);
        check_value("t5_cnt", {16'd0, stall_cnt}, 32'd0);

        // Clear in the threshold cycle, then reset while blocked
        step(3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < THR - 1; i++) step(3'b001, 3'b000, 1'b0, 1'b0, 1'b1);
        step(3'b001, 3'b000, 1'b0, 1'b1, 1'b1);
        check_value("t6_clr_block", {31'd0, block}, 32'd0);
        check_value("t6_clr_evt", {16'd0, event_cnt}, 32'd0);
        check_value("t6_clr_cnt", {16'd0, stall_cnt}, 32'd0);
        for (int i = 0; i < THR + 2; i++) step(3'b011, 3'b010, 1'b0, 1'b0, 1'b1);
        check_value("t6_blocked", {31'd0, block}, 32'd1);
        step(3'b011, 3'b010, 1'b0, 1'b0, 1'b0);
        check_value("t6_rst_block", {31'd0, block}, 32'd0);
        check_value("t6_rst_vec", {28'd0, block_vec}, 32'h0);

        // Randomized segments of held patterns
        for (int seg = 0; seg < 300; seg++) begin
            logic [3:0] pat;
            logic [2:0] idl;
            int len;
            pat = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) pat = 4'd0;
            idl = ($urandom_range(0, 9) < 8) ? 3'b000 : 3'($urandom_range(0, 7));
            len = (seg % 4 == 0) ? $urandom_range(THR - 2, THR + 6) : $urandom_range(1, 24);
            for (int c = 0; c < len; c++) begin
                step(pat[2:0], idl, pat[3],
                     ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 199) < 1) ? 1'b0 : 1'b1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_stall_deadlock_detector.md
Name: axis_stall_deadlock_detector

Overview:
Per-region deadlock detector fed by the kernel monitor's block/idle signal vectors (AXI-stream TDATA_blk_n inversions, sub-instance ap_idle, sub-instance block flags). Flags a deadlock when the same nonzero set of blocked channels persists, unchanged and with the kernel not fully idle, for a programmable number of cycles. Outputs a registered block flag plus diagnostics for the monitor top and the testbench.

Parameters:
NUM_AXIS, 3, number of AXI-stream block inputs (read A, read B, write out)
NUM_INST, 3, number of sub-instance idle inputs
NUM_IBLK, 1, number of sub-instance block inputs
STALL_THRESHOLD, 16, consecutive identical-stall cycles before deadlock is declared (>=2)
CNT_W, 16, width of stall and event counters

Ports:
ap_clk  in  1  clock; all logic on rising edge
ap_rst_n  in  1  synchronous active-low reset
axis_block_sigs  in  NUM_AXIS  1 = stream channel blocked this cycle
inst_idle_sigs  in  NUM_INST  1 = sub-instance idle
inst_block_sigs  in  NUM_IBLK  1 = sub-instance blocked
clear  in  1  synchronous clear of block state and counters
block  out  1  registered deadlock flag
block_vec  out  NUM_AXIS+NUM_IBLK  blocked-set latched at detection, {inst_block, axis_block}
stall_cnt  out  CNT_W  current consecutive-identical-stall count
event_cnt  out  CNT_W  number of BLOCKED entries, saturating

Behaviour:
- Reset (ap_rst_n=0 at a clock edge): state=IDLE; block=0; block_vec=0; stall_cnt=0; event_cnt=0; snapshot=0.
- Combinational: cur = {inst_block_sigs, axis_block_sigs}; any_blk = |cur; all_idle = &inst_idle_sigs; stall = any_blk & ~all_idle.
- States: IDLE, WATCH, BLOCKED.
- IDLE: if stall -> WATCH, snapshot<=cur, stall_cnt<=1. Otherwise stay; stall_cnt=0.
- WATCH:
  - ~stall -> IDLE, stall_cnt<=0.
  - stall and cur!=snapshot (progress or a different stall) -> stay, snapshot<=cur, stall_cnt<=1.
  - stall and cur==snapshot:
    - stall_cnt+1==STALL_THRESHOLD -> BLOCKED, block<=1, block_vec<=snapshot, event_cnt<=event_cnt+1 (saturate at all-ones), stall_cnt<=STALL_THRESHOLD.
    - otherwise stall_cnt<=stall_cnt+1.
- Latency: with the first stall cycle at T and cur constant, block reads 1 in cycle T+STALL_THRESHOLD.
- BLOCKED:
  - block held. stall_cnt saturates at all-ones (no wrap). block_vec is frozen.
  - ~stall -> IDLE, block<=0, stall_cnt<=0; block_vec retained until the next detection or clear.
  - stall with cur!=snapshot -> WATCH, block<=0, snapshot<=cur, stall_cnt<=1.
- clear=1: state=IDLE, block=0, block_vec=0, stall_cnt=0, snapshot=0, event_cnt=0. Clear overrides every same-cycle transition, including threshold reach. Reset overrides clear.
- all_idle=1 is never a stall, even if block bits are set (drained kernel).
- Reset asserted mid-WATCH or mid-BLOCKED: all outputs return to reset values at that edge. No partial count survives.
- Outputs are registered only; no combinational input-to-output path.

Optional Feature:
DEADLOCK_REPORT_EN:
- Defined: each WATCH->BLOCKED entry prints, via simulation-only code, $time, block_vec in binary and event_cnt. Also includes a sticky internal flag that a testbench can probe hierarchically.
- Undefined: no simulation-only constructs. RTL behaviour and ports are identical.

Test Plan:
1. Reset low 3 cycles, then high, idle inputs -> block=0, stall_cnt=0, event_cnt=0, block_vec=0.
2. axis_block_sigs=3'b001 held, inst_idle=3'b000, threshold 16, first stall cycle T -> block=1 at T+16, block_vec=4'b0001, event_cnt=1; stall_cnt=1 at T+1.
3. axis_block_sigs=3'b010 for 10 cycles, then 3'b100 for 10 cycles -> stall_cnt restarts at 1 on the change, never reaches 16, block stays 0.
4. In BLOCKED, drop all block bits for 1 cycle -> block=0 next cycle, state IDLE, block_vec still 4'b0001; re-stall 16 cycles -> event_cnt=2.
5. axis_block_sigs=3'b111 with inst_idle_sigs=3'b111 for 40 cycles -> block=0, stall_cnt=0.
6. Assert clear in the exact cycle stall_cnt would reach 16 -> block=0, all counters 0. Separately, ap_rst_n=0 while BLOCKED -> all outputs 0 next cycle.
